alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: (none; all widths fixed at 8-bit data, 4-bit op.)
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  command present.
REQ-005 req_ready  out  1  sequencer accepts command this cycle.
REQ-006 req_op / req_a / req_b / req_c / req_bcd  in  4/8/8/1/1  ALU opcode, operands, carry-in, decimal-mode request.
REQ-007 alu_op / alu_a / alu_b / alu_cin  out  4/8/8/1  drive to ALU.
REQ-008 alu_y / alu_zero / alu_negative / alu_overflow / alu_cout  in  8/1/1/1/1  ALU results.
REQ-009 rsp_valid  out  1  result held.
REQ-010 rsp_ready  in  1  consumer takes result.
REQ-011 rsp_y / rsp_c / rsp_z / rsp_n / rsp_v  out  8/1/1/1/1  final result and flags.

Function
REQ-012 States SHALL be IDLE, EXEC, ADJ_LO, ADJ_HI, DONE; one cycle each except IDLE and DONE.
REQ-013 IDLE: req_ready=1; req_valid=1 latches op/a/b/c/bcd and moves to EXEC; req_ready=0 in every other state.
REQ-014 EXEC: ALU driven with latched op/a/b/c; y, cout, zero, negative, overflow captured into result registers at end of cycle.
REQ-015 EXEC exit: ADJ_LO if decimal enabled and latched bcd=1 and op is 4'h2 (add) or 4'h3 (sub); otherwise DONE.
REQ-016 Half-carry hc = ae[4]^b[4]^y[4], ae = ~a for op 4'h3 else a, using EXEC-captured y.
REQ-017 ADJ_LO add: ALU op 4'h2, alu_a = 8'h06 if (y[3:0]>9 or hc) else 8'h00, alu_b = captured y, cin 0.
REQ-018 ADJ_LO sub: ALU op 4'h3, alu_a = 8'h06 if hc=0 else 8'h00, alu_b = y, cin 1.
REQ-019 ADJ_HI: same op/cin rule with 8'h60/8'h00; add adjusts if EXEC cout=1 or EXEC y>8'h99; sub adjusts if EXEC cout=0.
REQ-020 ADJ states SHALL always consume their cycle (adjust value 8'h00 when not needed) for fixed latency.
REQ-021 Decimal final flags: y, z, n from ADJ_HI ALU output; v from EXEC; c = add adjust-high condition, or EXEC cout for sub.
REQ-022 DONE: rsp_valid=1, rsp_* stable; rsp_ready=1 returns to IDLE; otherwise hold indefinitely.
REQ-023 Latency: accept at edge k -> rsp_valid high from cycle k+2 (binary) or k+4 (decimal).
REQ-024 Ops 4'h0-4'hF SHALL be passed unmodified to ALU; no opcode checking.
REQ-025 alu_* outputs SHALL be 0 in IDLE and DONE.
REQ-026 No overlap: a new command is accepted only in the cycle after a DONE handshake (IDLE).

Reset
REQ-027 reset=1 at an edge SHALL force IDLE from any state, including mid-EXEC/ADJ/DONE, discarding the command.
REQ-028 Post-reset: req_ready=1, rsp_valid=0, rsp_y=8'h00, all rsp flags 0, alu_* 0.

Configuration
REQ-029 Macro ALU_SEQ_BCD_EN defined: ADJ_LO/ADJ_HI and decimal flag rules built in.
REQ-030 Macro undefined: req_bcd ignored, ADJ states absent, EXEC always goes to DONE; all commands binary, latency k+2.

Verification
REQ-031 Binary add op 2, a=8'h50, b=8'h50, c=0 -> rsp_y=8'hA0, c=0, v=1, n=1, z=0, rsp_valid at k+2.
REQ-032 BCD add a=8'h45, b=8'h38, c=0, bcd=1 -> rsp_y=8'h83, c=0 at k+4 (macro undefined: 8'h7D at k+2).
REQ-033 BCD add a=8'h99, b=8'h01, c=0 -> rsp_y=8'h00, c=1, z=1.
REQ-034 BCD sub op 3, a=8'h15, b=8'h42, c=1 -> rsp_y=8'h27, c=1.
REQ-035 rsp_ready low 3 cycles in DONE with req_valid high -> rsp_* stable, req_ready=0, second command accepted only after handshake.
REQ-036 reset asserted during ADJ_LO -> next cycle IDLE, rsp_valid=0, req_ready=1, alu_* 0.

Source files
------------

// File: rtl/alu_seq.sv
// ALU sequencer: latches one command, steps it through an external ALU and holds the result.
// Define ALU_SEQ_BCD_EN to build in the two-cycle decimal adjust for BCD add (4'h2) and sub (4'h3).
module alu_seq (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [3:0] i_req_op,
  input  logic [7:0] i_req_a,
  input  logic [7:0] i_req_b,
  input  logic       i_req_c,
  input  logic       i_req_bcd,
  output logic [3:0] o_alu_op,
  output logic [7:0] o_alu_a,
  output logic [7:0] o_alu_b,
  output logic       o_alu_cin,
  input  logic [7:0] i_alu_y,
  input  logic       i_alu_zero,
  input  logic       i_alu_negative,
  input  logic       i_alu_overflow,
  input  logic       i_alu_cout,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [7:0] o_rsp_y,
  output logic       o_rsp_c,
  output logic       o_rsp_z,
  output logic       o_rsp_n,
  output logic       o_rsp_v
);

`ifdef ALU_SEQ_BCD_EN
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_ADJ_LO, S_ADJ_HI, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
`endif

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_c;
  logic [7:0] r_y;
  logic       r_cf;
  logic       r_z;
  logic       r_n;
  logic       r_v;

`ifdef ALU_SEQ_BCD_EN
  logic       r_bcd;
  logic [7:0] r_execY;
  logic       w_isSub;
  logic       w_decPath;
  logic       w_hc;
  logic       w_adjLo;
  logic       w_adjHi;

  // r_execY keeps the binary result because r_y is overwritten by the low adjust;
  // r_cf still holds the binary carry until the high adjust replaces it.
  assign w_isSub   = (r_op == 4'h3);
  assign w_decPath = r_bcd && ((r_op == 4'h2) || (r_op == 4'h3));
  assign w_hc      = (w_isSub ? ~r_a[4] : r_a[4]) ^ r_b[4] ^ r_execY[4];
  assign w_adjLo   = w_isSub ? ~w_hc : ((r_execY[3:0] > 4'd9) || w_hc);
  assign w_adjHi   = w_isSub ? ~r_cf : (r_cf || (r_execY > 8'h99));
`else
  logic w_unused;
  assign w_unused = i_req_bcd;
`endif

  always_comb begin
    w_next    = r_state;
    o_alu_op  = 4'h0;
    o_alu_a   = 8'h00;
    o_alu_b   = 8'h00;
    o_alu_cin = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) w_next = S_EXEC;
      end
      S_EXEC: begin
        o_alu_op  = r_op;
        o_alu_a   = r_a;
        o_alu_b   = r_b;
        o_alu_cin = r_c;
`ifdef ALU_SEQ_BCD_EN
        w_next    = w_decPath ? S_ADJ_LO : S_DONE;
`else
        w_next    = S_DONE;
`endif
      end
`ifdef ALU_SEQ_BCD_EN
      // Adjust cycles always run, with a zero adjust when none is needed, to keep latency fixed.
      S_ADJ_LO: begin
        o_alu_op  = r_op;
        o_alu_a   = w_adjLo ? 8'h06 : 8'h00;
        o_alu_b   = r_y;
        o_alu_cin = w_isSub;
        w_next    = S_ADJ_HI;
      end
      S_ADJ_HI: begin
        o_alu_op  = r_op;
        o_alu_a   = w_adjHi ? 8'h60 : 8'h00;
        o_alu_b   = r_y;
        o_alu_cin = w_isSub;
        w_next    = S_DONE;
      end
`endif
      S_DONE: begin
        if (i_rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_op    <= 4'h0;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_c     <= 1'b0;
      r_y     <= 8'h00;
      r_cf    <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
`ifdef ALU_SEQ_BCD_EN
      r_bcd   <= 1'b0;
      r_execY <= 8'h00;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_op  <= i_req_op;
            r_a   <= i_req_a;
            r_b   <= i_req_b;
            r_c   <= i_req_c;
`ifdef ALU_SEQ_BCD_EN
            r_bcd <= i_req_bcd;
`endif
          end
        end
        S_EXEC: begin
          r_y     <= i_alu_y;
          r_cf    <= i_alu_cout;
          r_z     <= i_alu_zero;
          r_n     <= i_alu_negative;
          r_v     <= i_alu_overflow;
`ifdef ALU_SEQ_BCD_EN
          r_execY <= i_alu_y;
`endif
        end
`ifdef ALU_SEQ_BCD_EN
        S_ADJ_LO: begin
          r_y <= i_alu_y;
        end
        // Decimal carry comes from the adjust decision for add, the binary borrow for sub.
        S_ADJ_HI: begin
          r_y  <= i_alu_y;
          r_z  <= i_alu_zero;
          r_n  <= i_alu_negative;
          r_cf <= w_isSub ? r_cf : w_adjHi;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_DONE);
  assign o_rsp_y     = r_y;
  assign o_rsp_c     = r_cf;
  assign o_rsp_z     = r_z;
  assign o_rsp_n     = r_n;
  assign o_rsp_v     = r_v;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural ALU attached to the DUT, randomized commands
// checked against an arithmetic reference model; honours ALU_SEQ_BCD_EN the same way as the design.
module tb_alu_seq;

   logic       clock;
   logic       reset;
   logic       reqValid;
   logic       reqReady;
   logic [3:0] reqOp;
   logic [7:0] reqA;
   logic [7:0] reqB;
   logic       reqC;
   logic       reqBcd;
   logic [3:0] aluOp;
   logic [7:0] aluA;
   logic [7:0] aluB;
   logic       aluCin;
   logic [7:0] aluY;
   logic       aluZero;
   logic       aluNegative;
   logic       aluOverflow;
   logic       aluCout;
   logic       rspValid;
   logic       rspReady;
   logic [7:0] rspY;
   logic       rspC;
   logic       rspZ;
   logic       rspN;
   logic       rspV;

   int testsRun;
   int testsFailed;

   typedef struct packed {
      logic [7:0] y;
      logic       c;
      logic       v;
   } alu_t;

   typedef struct packed {
      logic [7:0] y;
      logic       c;
      logic       z;
      logic       n;
      logic       v;
   } res_t;

   alu_seq dut (
      .i_clk(clock),
      .i_reset(reset),
      .i_req_valid(reqValid),
      .o_req_ready(reqReady),
      .i_req_op(reqOp),
      .i_req_a(reqA),
      .i_req_b(reqB),
      .i_req_c(reqC),
      .i_req_bcd(reqBcd),
      .o_alu_op(aluOp),
      .o_alu_a(aluA),
      .o_alu_b(aluB),
      .o_alu_cin(aluCin),
      .i_alu_y(aluY),
      .i_alu_zero(aluZero),
      .i_alu_negative(aluNegative),
      .i_alu_overflow(aluOverflow),
      .i_alu_cout(aluCout),
      .o_rsp_valid(rspValid),
      .i_rsp_ready(rspReady),
      .o_rsp_y(rspY),
      .o_rsp_c(rspC),
      .o_rsp_z(rspZ),
      .o_rsp_n(rspN),
      .o_rsp_v(rspV)
   );

   // Free-running clock, period 10
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Behavioural ALU: add is a+b+cin, sub is b-a with cin as not-borrow, others are simple logic ops
   function automatic alu_t aluFn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
      alu_t r;
      logic [8:0] s;
      r = '0;
      case (op)
         4'h0: r.y = a & b;
         4'h1: r.y = a | b;
         4'h2: begin
            s   = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            r.y = s[7:0];
            r.c = s[8];
            r.v = (a[7] == b[7]) && (s[7] != a[7]);
         end
         4'h3: begin
            s   = {1'b0, b} + {1'b0, ~a} + {8'h00, cin};
            r.y = s[7:0];
            r.c = s[8];
            r.v = (b[7] != a[7]) && (s[7] != b[7]);
         end
         4'h4: r.y = a ^ b;
         4'h5: begin
            r.y = {a[6:0], cin};
            r.c = a[7];
         end
         4'h6: begin
            r.y = {cin, a[7:1]};
            r.c = a[0];
         end
         default: begin
            r.y = a ^ b ^ {op, op};
            r.c = cin ^ op[0];
         end
      endcase
      return r;
   endfunction

   // ALU attached to the DUT's ALU port
   always_comb begin
      alu_t r;
      r           = aluFn(aluOp, aluA, aluB, aluCin);
      aluY        = r.y;
      aluCout     = r.c;
      aluOverflow = r.v;
      aluZero     = (r.y == 8'h00);
      aluNegative = r.y[7];
   end

   function automatic bit isDecimal(input logic [3:0] op, input logic bcd);
`ifdef ALU_SEQ_BCD_EN
      return bcd && (op == 4'h2 || op == 4'h3);
`else
      return 1'b0;
`endif
   endfunction

   // Reference model in plain integer arithmetic; decimal path follows the nibble adjust rules
   function automatic res_t refModel(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic c, input logic bcd);
      res_t r;
      alu_t o;
      int sa, sb, sum, sgn, lo, y1, y2;
      bit hc, adjH;
      r  = '0;
      sa = a[7] ? int'(a) - 256 : int'(a);
      sb = b[7] ? int'(b) - 256 : int'(b);
      if (op == 4'h2) begin
         sum = int'(a) + int'(b) + int'(c);
         sgn = sa + sb + int'(c);
         hc  = (int'(a[3:0]) + int'(b[3:0]) + int'(c)) > 15;
      end else if (op == 4'h3) begin
         sum = int'(b) + (255 - int'(a)) + int'(c);
         sgn = sb - sa - (c ? 0 : 1);
         hc  = (int'(b[3:0]) + (15 - int'(a[3:0])) + int'(c)) > 15;
      end else begin
         o    = aluFn(op, a, b, c);
         sum  = int'(o.y) + (o.c ? 256 : 0);
         sgn  = 0;
         hc   = 1'b0;
      end
      r.y = 8'(sum % 256);
      r.c = sum > 255;
      r.v = (sgn > 127) || (sgn < -128);
      if (isDecimal(op, bcd)) begin
         if (op == 4'h2) begin
            lo   = ((int'(r.y) % 16) > 9 || hc) ? 6 : 0;
            y1   = (int'(r.y) + lo) % 256;
            adjH = r.c || (int'(r.y) > 153);
            y2   = (y1 + (adjH ? 96 : 0)) % 256;
            r.c  = adjH;
         end else begin
            lo   = hc ? 0 : 6;
            y1   = (int'(r.y) - lo + 256) % 256;
            adjH = !r.c;
            y2   = (y1 - (adjH ? 96 : 0) + 256) % 256;
         end
         r.y = 8'(y2);
      end
      r.z = (r.y == 8'h00);
      r.n = r.y[7];
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
      testsRun++;
      if (got !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expected);
      end
   endtask

   // Runs one command end to end; rsp_ready is held low for holdCycles in DONE while a
   // competing request is offered, then the handshake is made.
   task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic c, input logic bcd, input int holdCycles);
      res_t exp;
      int   waitCnt;
      int   lat;
      exp = refModel(op, a, b, c, bcd);
      @(negedge clock);
      reqValid = 1'b1;
      reqOp    = op;
      reqA     = a;
      reqB     = b;
      reqC     = c;
      reqBcd   = bcd;
      waitCnt  = 0;
      while (!reqReady && waitCnt < 20) begin
         @(negedge clock);
         waitCnt++;
      end
      checkOutput("reqReadyBeforeAccept", 32'(reqReady), 32'd1);
      @(posedge clock);
      @(negedge clock);
      reqValid = 1'b0;
      reqOp    = 4'(~op);
      reqA     = ~a;
      reqB     = ~b;
      checkOutput("reqReadyBusy", 32'(reqReady), 32'd0);
      lat = 0;
      while (!rspValid && lat < 10) begin
         @(negedge clock);
         lat++;
      end
      checkOutput("latency", 32'(lat), isDecimal(op, bcd) ? 32'd3 : 32'd1);
      checkOutput("rspY", 32'(rspY), 32'(exp.y));
      checkOutput("rspFlags", {28'd0, rspC, rspZ, rspN, rspV}, {28'd0, exp.c, exp.z, exp.n, exp.v});
      checkOutput("aluIdleInDone", {15'd0, aluOp, aluA, aluB, aluCin}, 32'd0);
      for (int i = 0; i < holdCycles; i++) begin
         reqValid = 1'b1;
         reqOp    = 4'($urandom);
         reqA     = 8'($urandom);
         reqB     = 8'($urandom);
         @(negedge clock);
         checkOutput("holdValid", 32'(rspValid), 32'd1);
         checkOutput("holdReqReady", 32'(reqReady), 32'd0);
         checkOutput("holdRsp", {19'd0, rspY, rspC, rspZ, rspN, rspV}, {19'd0, exp.y, exp.c, exp.z, exp.n, exp.v});
      end
      reqValid = 1'b0;
      rspReady = 1'b1;
      @(negedge clock);
      rspReady = 1'b0;
      checkOutput("afterHandshakeReady", 32'(reqReady), 32'd1);
      checkOutput("afterHandshakeValid", 32'(rspValid), 32'd0);
   endtask

   // Watchdog so the run always ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, spec vectors, back-pressure, random traffic, mid-command reset
   initial begin
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      testsRun    = 0;
      testsFailed = 0;
      reset       = 1'b1;
      reqValid    = 1'b0;
      reqOp       = 4'h0;
      reqA        = 8'h00;
      reqB        = 8'h00;
      reqC        = 1'b0;
      reqBcd      = 1'b0;
      rspReady    = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      checkOutput("resetReqReady", 32'(reqReady), 32'd1);
      checkOutput("resetRspValid", 32'(rspValid), 32'd0);
      checkOutput("resetRsp", {19'd0, rspY, rspC, rspZ, rspN, rspV}, 32'd0);
      checkOutput("resetAlu", {15'd0, aluOp, aluA, aluB, aluCin}, 32'd0);

      applyStimulus(4'h2, 8'h50, 8'h50, 1'b0, 1'b0, 0);
      applyStimulus(4'h2, 8'h45, 8'h38, 1'b0, 1'b1, 0);
      applyStimulus(4'h2, 8'h99, 8'h01, 1'b0, 1'b1, 0);
      applyStimulus(4'h3, 8'h15, 8'h42, 1'b1, 1'b1, 0);
      applyStimulus(4'h3, 8'h42, 8'h15, 1'b1, 1'b1, 3);
      applyStimulus(4'h2, 8'h45, 8'h38, 1'b0, 1'b0, 0);

      for (int n = 0; n < 60; n++) begin
         op = 4'($urandom_range(0, 15));
         if (n % 2 == 0) op = 4'($urandom_range(2, 3));
         if ($urandom_range(0, 1) == 1) begin
            a = 8'(($urandom_range(0, 9) << 4) | $urandom_range(0, 9));
            b = 8'(($urandom_range(0, 9) << 4) | $urandom_range(0, 9));
         end else begin
            a = 8'($urandom);
            b = 8'($urandom);
         end
         applyStimulus(op, a, b, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end

      // Reset two edges after accept: ADJ_LO in decimal builds, DONE otherwise
      @(negedge clock);
      reqValid = 1'b1;
      reqOp    = 4'h2;
      reqA     = 8'h45;
      reqB     = 8'h38;
      reqC     = 1'b0;
      reqBcd   = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reqValid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checkOutput("midResetReqReady", 32'(reqReady), 32'd1);
      checkOutput("midResetRspValid", 32'(rspValid), 32'd0);
      checkOutput("midResetRsp", {19'd0, rspY, rspC, rspZ, rspN, rspV}, 32'd0);
      checkOutput("midResetAlu", {15'd0, aluOp, aluA, aluB, aluCin}, 32'd0);
      applyStimulus(4'h3, 8'h01, 8'h00, 1'b1, 1'b1, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
